// File: rtl/jcn_pkg.sv
// Shared encodings for the jcn_led_seq pattern sequencer.
package jcn_pkg;

  localparam logic [1:0] MODE_JOHNSON = 2'b00;
  localparam logic [1:0] MODE_RING    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE  = 2'b10;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/sw_debounce.sv
// Active-low push-button debouncer: 2-FF synchroniser plus stability counter.
// A level must differ from the accepted level for DB_LEN consecutive cycles.
module sw_debounce #(
  parameter int unsigned DB_LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic db_n
);

  localparam int unsigned CntW = (DB_LEN > 2) ? $clog2(DB_LEN) : 1;

  logic            r_s1;
  logic            r_s2;
  logic            r_db;
  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= 1'b1;
      r_s2  <= 1'b1;
      r_db  <= 1'b1;
      r_cnt <= '0;
    end else begin
      r_s1 <= raw_n;
      r_s2 <= r_s1;
      if (r_s2 != r_db) begin
        if (r_cnt == CntW'(DB_LEN - 1)) begin
          r_db  <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign db_n = r_db;

endmodule

// File: rtl/jcn_led_seq.sv
// Johnson / ring / bounce LED pattern sequencer with debounced switches
// and a programmable step-rate prescaler.
module jcn_led_seq
  import jcn_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DIV_W  = 24,
  parameter int unsigned DB_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             left_n,
  input  logic             right_n,
  input  logic             stop_n,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] q_n,
  output logic             running,
  output logic             dir
);

  logic w_db_left_n;
  logic w_db_right_n;
  logic w_db_stop_n;

  sw_debounce #(.DB_LEN(DB_LEN)) u_db_left (
    .clk   (clk),
    .rst   (rst),
    .raw_n (left_n),
    .db_n  (w_db_left_n)
  );

  sw_debounce #(.DB_LEN(DB_LEN)) u_db_right (
    .clk   (clk),
    .rst   (rst),
    .raw_n (right_n),
    .db_n  (w_db_right_n)
  );

  sw_debounce #(.DB_LEN(DB_LEN)) u_db_stop (
    .clk   (clk),
    .rst   (rst),
    .raw_n (stop_n),
    .db_n  (w_db_stop_n)
  );

  logic [WIDTH-1:0] r_pat;
  logic             r_dir;
  logic             r_run;
  logic [1:0]       r_mode;
  logic [DIV_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_pat_d;
  logic             w_dir_d;
  logic             w_auto_dir;
  logic             w_run_d;
  logic [DIV_W-1:0] w_cnt_d;
  logic             w_mode_chg;
  logic             w_tick;
  logic             w_onehot;

  always_comb begin
    w_mode_chg = (mode != r_mode);
    w_tick     = r_run && (r_cnt == div) && !w_mode_chg;
    w_onehot   = (r_pat != '0) && ((r_pat & (r_pat - WIDTH'(1))) == '0);

    if (!r_run || w_mode_chg || (r_cnt == div)) w_cnt_d = '0;
    else                                        w_cnt_d = r_cnt + DIV_W'(1);
  end

  // Pattern step; bounce may also request a direction reversal.
  always_comb begin
    w_pat_d    = r_pat;
    w_auto_dir = r_dir;
    if (w_mode_chg) begin
      w_pat_d = ((mode == MODE_RING) || (mode == MODE_BOUNCE)) ? WIDTH'(1) : '0;
    end else if (w_tick) begin
      case (r_mode)
        MODE_RING: begin
          if (!w_onehot)             w_pat_d = WIDTH'(1);
          else if (r_dir == DIR_LEFT) w_pat_d = {r_pat[WIDTH-2:0], r_pat[WIDTH-1]};
          else                        w_pat_d = {r_pat[0], r_pat[WIDTH-1:1]};
        end
        MODE_BOUNCE: begin
          if (!w_onehot) begin
            w_pat_d = WIDTH'(1);
          end else if (r_dir == DIR_LEFT) begin
            if (r_pat[WIDTH-1]) begin
              w_pat_d    = r_pat >> 1;
              w_auto_dir = DIR_RIGHT;
            end else begin
              w_pat_d = r_pat << 1;
            end
          end else begin
            if (r_pat[0]) begin
              w_pat_d    = r_pat << 1;
              w_auto_dir = DIR_LEFT;
            end else begin
              w_pat_d = r_pat >> 1;
            end
          end
        end
        default: begin
          if (r_dir == DIR_LEFT) w_pat_d = {r_pat[WIDTH-2:0], ~r_pat[WIDTH-1]};
          else                   w_pat_d = {~r_pat[0], r_pat[WIDTH-1:1]};
        end
      endcase
    end
  end

  // Switches override any bounce reversal; stop overrides everything.
  always_comb begin
    if (!w_db_right_n)     w_dir_d = DIR_RIGHT;
    else if (!w_db_left_n) w_dir_d = DIR_LEFT;
    else                   w_dir_d = w_auto_dir;

    if (!w_db_stop_n)                      w_run_d = 1'b0;
    else if (!w_db_left_n || !w_db_right_n) w_run_d = 1'b1;
    else                                   w_run_d = r_run;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat  <= '0;
      r_dir  <= DIR_RIGHT;
      r_run  <= 1'b0;
      r_mode <= MODE_JOHNSON;
      r_cnt  <= '0;
    end else begin
      r_pat  <= w_pat_d;
      r_dir  <= w_dir_d;
      r_run  <= w_run_d;
      r_mode <= mode;
      r_cnt  <= w_cnt_d;
    end
  end

  assign q_n     = ~r_pat;
  assign running = r_run;
  assign dir     = r_dir;

endmodule

// File: tb/tb_jcn_led_seq.sv
// Directed bench for jcn_led_seq (WIDTH=4, DB_LEN=4) with hand-computed expectations.
module tb_jcn_led_seq;

  localparam int unsigned Width  = 4;
  localparam int unsigned DivW   = 24;
  localparam int unsigned DbLen  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             left_n;
  logic             right_n;
  logic             stop_n;
  logic [1:0]       mode;
  logic [DivW-1:0]  div;
  logic [Width-1:0] q_n;
  logic             running;
  logic             dir;

  int n_checks = 0;
  int n_fail   = 0;

  jcn_led_seq #(
    .WIDTH  (Width),
    .DIV_W  (DivW),
    .DB_LEN (DbLen)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .left_n  (left_n),
    .right_n (right_n),
    .stop_n  (stop_n),
    .mode    (mode),
    .div     (div),
    .q_n     (q_n),
    .running (running),
    .dir     (dir)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] jexp [9];

  initial begin
    jexp[0] = 4'hE; jexp[1] = 4'hC; jexp[2] = 4'h8; jexp[3] = 4'h0; jexp[4] = 4'h1;
    jexp[5] = 4'h3; jexp[6] = 4'h7; jexp[7] = 4'hF; jexp[8] = 4'hE;

    rst = 1'b1; left_n = 1'b1; right_n = 1'b1; stop_n = 1'b1; mode = 2'b00; div = '0;
    cyc(2);
    rst = 1'b0;
    chk("reset_qn", 32'(q_n), 32'hF);
    chk("reset_running", 32'(running), 32'h0);
    chk("reset_dir", 32'(dir), 32'h0);

    // Short glitch is rejected
    left_n = 1'b0;
    cyc(3);
    left_n = 1'b1;
    cyc(10);
    chk("glitch_running", 32'(running), 32'h0);
    chk("glitch_qn", 32'(q_n), 32'hF);

    // Held press: running rises DB_LEN+3 edges after the raw edge
    left_n = 1'b0;
    cyc(DbLen + 2);
    chk("press_early_running", 32'(running), 32'h0);
    cyc(1);
    chk("press_running", 32'(running), 32'h1);
    chk("press_dir", 32'(dir), 32'h1);
    chk("press_qn", 32'(q_n), 32'hF);

    for (int i = 0; i < 9; i++) begin
      cyc(1);
      chk($sformatf("johnson_left_%0d", i), 32'(q_n), 32'(jexp[i]));
    end

    // Right and left together: right wins
    right_n = 1'b0;
    cyc(7);
    chk("both_qn", 32'(q_n), 32'hF);
    chk("both_dir", 32'(dir), 32'h0);
    chk("both_running", 32'(running), 32'h1);
    cyc(1);
    chk("johnson_right_0", 32'(q_n), 32'h7);
    cyc(1);
    chk("johnson_right_1", 32'(q_n), 32'h3);

    // Stop with left held: stop wins, step still happens on the drop edge
    right_n = 1'b1;
    stop_n  = 1'b0;
    cyc(6);
    chk("stop_early_running", 32'(running), 32'h1);
    chk("stop_early_qn", 32'(q_n), 32'hF);
    cyc(1);
    chk("stop_running", 32'(running), 32'h0);
    chk("stop_qn", 32'(q_n), 32'h7);
    chk("stop_dir", 32'(dir), 32'h1);
    cyc(5);
    chk("frozen_qn", 32'(q_n), 32'h7);
    chk("frozen_running", 32'(running), 32'h0);

    // Prescaler div=3
    div    = DivW'(3);
    stop_n = 1'b1;
    cyc(6);
    chk("restart_early_running", 32'(running), 32'h0);
    cyc(1);
    chk("restart_running", 32'(running), 32'h1);
    left_n = 1'b1;
    cyc(3);
    chk("div3_hold_0", 32'(q_n), 32'h7);
    cyc(1);
    chk("div3_step_0", 32'(q_n), 32'hF);
    cyc(3);
    chk("div3_hold_1", 32'(q_n), 32'hF);
    cyc(1);
    chk("div3_step_1", 32'(q_n), 32'hE);

    // Bounce mode
    div  = '0;
    mode = 2'b10;
    cyc(1);
    chk("bounce_reload", 32'(q_n), 32'hE);
    chk("bounce_dir_start", 32'(dir), 32'h1);
    cyc(1); chk("bounce_1", 32'(q_n), 32'hD);
    cyc(1); chk("bounce_2", 32'(q_n), 32'hB);
    cyc(1); chk("bounce_3", 32'(q_n), 32'h7);
    cyc(1); chk("bounce_4", 32'(q_n), 32'hB);
    chk("bounce_dir_flip_r", 32'(dir), 32'h0);
    cyc(1); chk("bounce_5", 32'(q_n), 32'hD);
    cyc(1); chk("bounce_6", 32'(q_n), 32'hE);
    cyc(1); chk("bounce_7", 32'(q_n), 32'hD);
    chk("bounce_dir_flip_l", 32'(dir), 32'h1);

    // Ring mode
    mode = 2'b01;
    cyc(1); chk("ring_reload", 32'(q_n), 32'hE);
    cyc(1); chk("ring_1", 32'(q_n), 32'hD);
    cyc(1); chk("ring_2", 32'(q_n), 32'hB);
    cyc(1); chk("ring_3", 32'(q_n), 32'h7);
    cyc(1); chk("ring_wrap", 32'(q_n), 32'hE);

    // Mode change back to Johnson mid-run: reload, no step that cycle
    mode = 2'b00;
    cyc(1); chk("johnson_reload", 32'(q_n), 32'hF);
    cyc(1); chk("johnson_after_1", 32'(q_n), 32'hE);
    cyc(1); chk("johnson_after_2", 32'(q_n), 32'hC);

    // Reset mid-sequence
    rst = 1'b1;
    cyc(1);
    chk("midrst_qn", 32'(q_n), 32'hF);
    chk("midrst_running", 32'(running), 32'h0);
    chk("midrst_dir", 32'(dir), 32'h0);
    rst = 1'b0;
    cyc(3);
    chk("postrst_qn", 32'(q_n), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
